state_update_ctrl: RTL and testbench
====================================

Name: state_update_ctrl

Overview:
- Sequencer for the 128-bit Romulus-N state-update datapath, which absorbs or encrypts the state as four 32-bit beats and reloads it from the SKINNY core.
- Per block, it drives the datapath shift-enable (se), the reload-from-SKINNY enable (enc) and the per-byte decrypt select.
- It handshakes the 32-bit pdi input stream and the pdo output stream, and starts the SKINNY core and waits for it to finish.
- It sits between the mode controller (which issues block commands) and the state_update/SKINNY datapath.

Parameters:
- TIMEOUT, 64: maximum number of cycles spent in WAIT before err is set. Legal range 2..255.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- blk_start  in  1  command strobe; sampled only in IDLE.
- blk_type  in  2  block type: 00 = AD, 01 = message, 10 = tag, 11 = reserved (treated as AD).
- blk_bytes  in  5  number of valid bytes in the block. 0 or values above 16 are treated as 16. Latched on blk_start.
- decrypt_mode  in  1  1 = decryption. Latched on blk_start.
- pdi_valid  in  1  input beat available.
- pdi_ready  out  1  input beat accepted when pdi_valid && pdi_ready.
- pdo_valid  out  1  output beat available.
- pdo_ready  in  1  downstream accepts the output beat.
- pdo_byte_en  out  4  valid-byte mask for the current output beat.
- zero_pdi  out  1  upstream must drive pdi = 0 (tag beats).
- se  out  1  datapath shift/absorb enable.
- enc  out  1  datapath reload from skinny_state.
- decrypt  out  4  per-byte decrypt select to the datapath.
- skinny_start  out  1  single-cycle SKINNY start pulse.
- skinny_done  in  1  SKINNY result valid (level or pulse).
- busy  out  1  high whenever the state is not IDLE.
- blk_done  out  1  single-cycle pulse when the block completes.
- err  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Reset: asynchronous. The FSM goes to IDLE and the beat counter goes to 0. Every output is 0, including err. A reset mid-block aborts the block with no further se or enc.
- States: IDLE, ABSORB, TAG, KICK, WAIT, LOAD, DONE.
- IDLE:
  - On blk_start, latch the command fields.
  - Go to TAG if blk_type = 10; otherwise go to ABSORB. Clear beat counter k.
- Byte validity: byte j of beat k is valid iff 4k+j < eff_bytes, where beat 0 carries state[127:96] and beat 3 carries state[31:0].
- ABSORB (4 beats):
  - pdi_ready = (type != MSG) || !any_valid(k) || pdo_ready.
  - pdo_valid = (type == MSG) && any_valid(k) && pdi_valid.
  - pdo_byte_en = valid mask when pdo_valid, else 0.
  - A beat fires when pdi_valid && pdi_ready. On a firing beat, se = 1.
  - decrypt[j] = decrypt_mode && (type == MSG) && valid(k,j), driven combinationally in ABSORB.
  - Upstream supplies the padded data in pad bytes.
  - When beat 3 fires, go to KICK. k wraps to 0.
- KICK: skinny_start = 1 for one cycle, then go to WAIT.
- WAIT:
  - On skinny_done, go to LOAD.
  - A cycle counter counts cycles in WAIT. When it reaches TIMEOUT, set err and go to IDLE with no LOAD and no blk_done.
- LOAD: enc = 1 for one cycle, then go to DONE.
- DONE: blk_done = 1 for one cycle, then go to IDLE.
- TAG (4 beats):
  - zero_pdi = 1 and pdi_ready = 0.
  - pdo_valid = 1 and pdo_byte_en = 1111.
  - A beat fires on pdo_ready, and se = 1 on that beat. This rotates the state four times, restoring it to its original value.
  - After the 4th beat, go directly to DONE (no SKINNY).
- Invariants:
  - se and enc are never high in the same cycle.
  - se, enc, skinny_start and decrypt are 0 outside their states.
  - blk_start outside IDLE is ignored.
  - A skinny_done outside WAIT is ignored.
- Latency (AD block, pdi_valid held high, blk_start at cycle T):
  - Beats fire at T+1..T+4.
  - skinny_start at T+5.
  - If skinny_done is first seen in cycle D, enc is at D+1 and blk_done at D+2.

Test Plan:
- Full 16-byte AD block with pdi_valid held high and skinny_done 10 cycles after skinny_start:
  - se high exactly at T+1..T+4.
  - skinny_start at T+5.
  - enc exactly one cycle after skinny_done.
  - blk_done one cycle after enc.
  - pdo_valid never asserted; decrypt = 0.
- Message decrypt, blk_bytes = 6, pdo_ready stalled low for 3 cycles on beat 0:
  - pdi_ready stays low during the stall.
  - Beat 0: decrypt = 1111, pdo_byte_en = 1111.
  - Beat 1: decrypt = 0011, pdo_byte_en = 0011 (bytes 4 and 5).
  - Beats 2–3: decrypt = 0, pdo_valid = 0, and these beats fire with pdo_ready low.
- Tag block:
  - zero_pdi = 1 and pdo_byte_en = 1111 for 4 accepted beats.
  - No skinny_start.
  - blk_done the cycle after the 4th beat.
  - Datapath state equals its pre-tag value.
- blk_bytes = 0 and blk_bytes = 20: behave identically to 16 (all beats fully valid).
- skinny_done never arrives with TIMEOUT = 8:
  - err rises after 8 WAIT cycles and the FSM returns to IDLE.
  - No enc and no blk_done.
  - The next blk_start is accepted.
- rst pulled low mid-ABSORB after 2 beats:
  - All outputs 0 immediately (asynchronously).
  - After release, a new AD block completes normally with 4 fresh beats.
  - A blk_start asserted during busy is ignored.

Source files
------------

// File: rtl/state_update_ctrl_if.sv
// Handshake and control bundle for the Romulus-N state-update sequencer.
// Master side is the mode controller / datapath environment; slave is the sequencer.
interface state_update_ctrl_if;
    logic       blk_start;
    logic [1:0] blk_type;
    logic [4:0] blk_bytes;
    logic       decrypt_mode;
    logic       pdi_valid;
    logic       pdi_ready;
    logic       pdo_valid;
    logic       pdo_ready;
    logic [3:0] pdo_byte_en;
    logic       zero_pdi;
    logic       se;
    logic       enc;
    logic [3:0] decrypt;
    logic       skinny_start;
    logic       skinny_done;
    logic       busy;
    logic       blk_done;
    logic       err;

    modport master (
        output blk_start, blk_type, blk_bytes, decrypt_mode,
        output pdi_valid, pdo_ready, skinny_done,
        input  pdi_ready, pdo_valid, pdo_byte_en, zero_pdi,
        input  se, enc, decrypt, skinny_start, busy, blk_done, err
    );

    modport slave (
        input  blk_start, blk_type, blk_bytes, decrypt_mode,
        input  pdi_valid, pdo_ready, skinny_done,
        output pdi_ready, pdo_valid, pdo_byte_en, zero_pdi,
        output se, enc, decrypt, skinny_start, busy, blk_done, err
    );
endinterface

// File: rtl/state_update_ctrl.sv
// Block sequencer for the Romulus-N 128-bit state-update datapath.
// Streams four 32-bit beats, kicks SKINNY, waits for it and reloads the state.
module state_update_ctrl #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    state_update_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABSORB,
        S_TAG,
        S_KICK,
        S_WAIT,
        S_LOAD,
        S_DONE
    } state_t;

    localparam logic [1:0] T_MSG   = 2'b01;
    localparam logic [1:0] T_TAG   = 2'b10;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t     state_q;
    logic [1:0] type_q;
    logic [1:0] k_q;
    logic [4:0] eff_q;
    logic       dec_q;
    logic [7:0] wcnt_q;
    logic       err_q;

    logic [4:0] eff_d;
    logic [3:0] vmask;
    logic       any_v;
    logic       is_msg;
    logic       fire;

    // Zero-length and oversize blocks both mean a full 16-byte block.
    always_comb begin
        eff_d = bus.blk_bytes;
        if (bus.blk_bytes == 5'd0 || bus.blk_bytes > 5'd16) begin
            eff_d = 5'd16;
        end
    end

    // Byte j of beat k is valid while 4k+j is below the effective length.
    always_comb begin
        vmask = '0;
        for (int j = 0; j < 4; j++) begin
            vmask[j] = ({1'b0, k_q, 2'b00} + 5'(j)) < eff_q;
        end
    end

    assign any_v  = |vmask;
    assign is_msg = (type_q == T_MSG);

    // Output decode; everything depends on the state register so an
    // asynchronous reset silences the datapath immediately.
    always_comb begin
        bus.pdi_ready    = 1'b0;
        bus.pdo_valid    = 1'b0;
        bus.pdo_byte_en  = 4'b0000;
        bus.zero_pdi     = 1'b0;
        bus.se           = 1'b0;
        bus.enc          = 1'b0;
        bus.decrypt      = 4'b0000;
        bus.skinny_start = 1'b0;
        bus.blk_done     = 1'b0;
        fire             = 1'b0;
        unique case (state_q)
            S_ABSORB: begin
                bus.pdi_ready = !is_msg || !any_v || bus.pdo_ready;
                bus.pdo_valid = is_msg && any_v && bus.pdi_valid;
                if (bus.pdo_valid) begin
                    bus.pdo_byte_en = vmask;
                end
                bus.decrypt = {4{dec_q && is_msg}} & vmask;
                fire        = bus.pdi_valid && bus.pdi_ready;
                bus.se      = fire;
            end
            S_TAG: begin
                bus.zero_pdi    = 1'b1;
                bus.pdo_valid   = 1'b1;
                bus.pdo_byte_en = 4'b1111;
                fire            = bus.pdo_ready;
                bus.se          = fire;
            end
            S_KICK: bus.skinny_start = 1'b1;
            S_LOAD: bus.enc          = 1'b1;
            S_DONE: bus.blk_done     = 1'b1;
            default: ;
        endcase
    end

    assign bus.busy = (state_q != S_IDLE);
    assign bus.err  = err_q;

    // Block FSM: command latch, beat counter, SKINNY wait timer, error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            type_q  <= 2'b00;
            k_q     <= 2'b00;
            eff_q   <= 5'd0;
            dec_q   <= 1'b0;
            wcnt_q  <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.blk_start) begin
                        type_q  <= bus.blk_type;
                        eff_q   <= eff_d;
                        dec_q   <= bus.decrypt_mode;
                        k_q     <= 2'b00;
                        state_q <= (bus.blk_type == T_TAG) ? S_TAG : S_ABSORB;
                    end
                end
                S_ABSORB, S_TAG: begin
                    if (fire) begin
                        k_q <= k_q + 2'd1;
                        if (k_q == 2'd3) begin
                            state_q <= (state_q == S_TAG) ? S_DONE : S_KICK;
                        end
                    end
                end
                S_KICK: begin
                    wcnt_q  <= 8'd0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.skinny_done) begin
                        state_q <= S_LOAD;
                    end else if (wcnt_q == TO_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        wcnt_q <= wcnt_q + 8'd1;
                    end
                end
                S_LOAD: state_q <= S_DONE;
                S_DONE: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_state_update_ctrl.sv
// Directed bench for state_update_ctrl: vector table plus multi-cycle sequences.
// A second instance with a short timeout covers the SKINNY watchdog.
module tb_state_update_ctrl;

    logic       clk;
    logic       rst;
    logic       blk_start;
    logic [1:0] blk_type;
    logic [4:0] blk_bytes;
    logic       decrypt_mode;
    logic       pdi_valid;
    logic       pdo_ready;
    logic       skinny_done;

    int n_tests = 0;
    int n_fail  = 0;

    state_update_ctrl_if bus_a ();
    state_update_ctrl_if bus_t ();

    assign bus_a.blk_start    = blk_start;
    assign bus_a.blk_type     = blk_type;
    assign bus_a.blk_bytes    = blk_bytes;
    assign bus_a.decrypt_mode = decrypt_mode;
    assign bus_a.pdi_valid    = pdi_valid;
    assign bus_a.pdo_ready    = pdo_ready;
    assign bus_a.skinny_done  = skinny_done;
    assign bus_t.blk_start    = blk_start;
    assign bus_t.blk_type     = blk_type;
    assign bus_t.blk_bytes    = blk_bytes;
    assign bus_t.decrypt_mode = decrypt_mode;
    assign bus_t.pdi_valid    = pdi_valid;
    assign bus_t.pdo_ready    = pdo_ready;
    assign bus_t.skinny_done  = skinny_done;

    state_update_ctrl #(.TIMEOUT(64)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    state_update_ctrl #(.TIMEOUT(8))  dut_t (.clk(clk), .rst(rst), .bus(bus_t));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [16:0] oa;
    logic [16:0] ot;
    assign oa = {bus_a.busy, bus_a.err, bus_a.pdi_ready, bus_a.pdo_valid,
                 bus_a.pdo_byte_en, bus_a.zero_pdi, bus_a.se, bus_a.enc,
                 bus_a.decrypt, bus_a.skinny_start, bus_a.blk_done};
    assign ot = {bus_t.busy, bus_t.err, bus_t.pdi_ready, bus_t.pdo_valid,
                 bus_t.pdo_byte_en, bus_t.zero_pdi, bus_t.se, bus_t.enc,
                 bus_t.decrypt, bus_t.skinny_start, bus_t.blk_done};

    // Simple datapath model: each se rotates by one beat, xoring pdi in.
    logic [127:0] st;
    logic [127:0] st_init;
    logic         ld;
    localparam logic [31:0] PDI = 32'hA5A5_0F0F;
    always @(posedge clk) begin
        if (ld) st <= st_init;
        else if (bus_a.se)
            st <= {st[95:0], st[127:96] ^ (bus_a.zero_pdi ? 32'h0 : PDI)};
    end

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        blk_start = 1'b0;
        pdi_valid = 1'b0;
        pdo_ready = 1'b0;
        skinny_done = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Returns one ns into cycle T+1, where T is the blk_start cycle.
    task automatic start_blk(input logic [1:0] t, input logic [4:0] b,
                             input logic dm);
        @(posedge clk);
        #1;
        blk_start = 1'b1;
        blk_type = t;
        blk_bytes = b;
        decrypt_mode = dm;
        @(posedge clk);
        #1;
        blk_start = 1'b0;
    endtask

    typedef struct {
        logic [1:0] typ;
        logic [4:0] bytes;
        logic       dm;
        int         k;
        logic       pv;
        logic       pr;
        logic       e_rdy;
        logic       e_vld;
        logic [3:0] e_ben;
        logic [3:0] e_dec;
        logic       e_se;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [4:0] prs;
        logic [4:0] bsel [2];
        ld = 1'b0;
        st_init = '0;
        blk_type = 2'b00;
        blk_bytes = 5'd0;
        decrypt_mode = 1'b0;

        //          typ    bytes dm k pv pr  rdy vld ben      dec      se
        vecs[0]  = '{2'b00, 5'd16, 1, 0, 1, 0, 1, 0, 4'b0000, 4'b0000, 1};
        vecs[1]  = '{2'b01, 5'd6,  1, 0, 1, 0, 0, 1, 4'b1111, 4'b1111, 0};
        vecs[2]  = '{2'b01, 5'd6,  1, 1, 1, 1, 1, 1, 4'b0011, 4'b0011, 1};
        vecs[3]  = '{2'b01, 5'd6,  1, 2, 1, 0, 1, 0, 4'b0000, 4'b0000, 1};
        vecs[4]  = '{2'b01, 5'd6,  0, 1, 1, 1, 1, 1, 4'b0011, 4'b0000, 1};
        vecs[5]  = '{2'b01, 5'd0,  1, 3, 1, 1, 1, 1, 4'b1111, 4'b1111, 1};
        vecs[6]  = '{2'b01, 5'd20, 1, 3, 0, 1, 1, 0, 4'b0000, 4'b1111, 0};
        vecs[7]  = '{2'b01, 5'd16, 1, 2, 1, 1, 1, 1, 4'b1111, 4'b1111, 1};
        vecs[8]  = '{2'b11, 5'd5,  1, 1, 1, 0, 1, 0, 4'b0000, 4'b0000, 1};
        vecs[9]  = '{2'b01, 5'd13, 1, 3, 1, 1, 1, 1, 4'b0001, 4'b0001, 1};
        vecs[10] = '{2'b01, 5'd5,  1, 1, 0, 0, 0, 0, 4'b0000, 4'b0001, 0};
        vecs[11] = '{2'b01, 5'd4,  1, 1, 1, 0, 1, 0, 4'b0000, 4'b0000, 1};

        // Reset state
        rst = 1'b0;
        blk_start = 1'b0;
        pdi_valid = 1'b0;
        pdo_ready = 1'b0;
        skinny_done = 1'b0;
        #3;
        chk("reset_outs", oa, 0);
        do_reset();
        @(negedge clk);
        chk("idle_outs", oa, 0);

        // Combinational ABSORB decode at a chosen beat
        for (int i = 0; i < 12; i++) begin
            do_reset();
            start_blk(vecs[i].typ, vecs[i].bytes, vecs[i].dm);
            pdi_valid = 1'b1;
            pdo_ready = 1'b1;
            repeat (vecs[i].k) begin
                @(posedge clk);
                #1;
            end
            pdi_valid = vecs[i].pv;
            pdo_ready = vecs[i].pr;
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                {bus_a.pdi_ready, bus_a.pdo_valid, bus_a.pdo_byte_en,
                 bus_a.decrypt, bus_a.se},
                {vecs[i].e_rdy, vecs[i].e_vld, vecs[i].e_ben,
                 vecs[i].e_dec, vecs[i].e_se});
        end

        // Full AD block, skinny_done 10 cycles after skinny_start
        do_reset();
        start_blk(2'b00, 5'd16, 1'b0);
        pdi_valid = 1'b1;
        pdo_ready = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            skinny_done = (c == 15);
            @(negedge clk);
            chk($sformatf("ad_c%0d", c),
                {bus_a.busy, bus_a.se, bus_a.skinny_start, bus_a.enc,
                 bus_a.blk_done, bus_a.pdo_valid, bus_a.decrypt},
                {c <= 17, c >= 1 && c <= 4, c == 5, c == 16,
                 c == 17, 1'b0, 4'b0000});
            @(posedge clk);
            #1;
        end
        skinny_done = 1'b0;

        // Message decrypt, 6 bytes, beat 0 stalled on pdo_ready
        do_reset();
        start_blk(2'b01, 5'd6, 1'b1);
        pdi_valid = 1'b1;
        pdo_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("msg_stall%0d", c),
                {bus_a.pdi_ready, bus_a.pdo_valid, bus_a.se,
                 bus_a.decrypt, bus_a.pdo_byte_en},
                {1'b0, 1'b1, 1'b0, 4'b1111, 4'b1111});
            @(posedge clk);
            #1;
        end
        pdo_ready = 1'b1;
        @(negedge clk);
        chk("msg_beat0",
            {bus_a.pdi_ready, bus_a.pdo_valid, bus_a.se,
             bus_a.decrypt, bus_a.pdo_byte_en},
            {1'b1, 1'b1, 1'b1, 4'b1111, 4'b1111});
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("msg_beat1",
            {bus_a.pdi_ready, bus_a.pdo_valid, bus_a.se,
             bus_a.decrypt, bus_a.pdo_byte_en},
            {1'b1, 1'b1, 1'b1, 4'b0011, 4'b0011});
        @(posedge clk);
        #1;
        pdo_ready = 1'b0;
        for (int c = 2; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("msg_beat%0d", c),
                {bus_a.pdi_ready, bus_a.pdo_valid, bus_a.se,
                 bus_a.decrypt, bus_a.pdo_byte_en},
                {1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000});
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("msg_kick", {bus_a.skinny_start, bus_a.se}, {1'b1, 1'b0});

        // Tag block with one stall cycle; state must come back unchanged
        do_reset();
        st_init = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        ld = 1'b1;
        @(posedge clk);
        #1 ld = 1'b0;
        start_blk(2'b10, 5'd0, 1'b0);
        prs = 5'b11011;
        for (int i = 0; i < 5; i++) begin
            pdo_ready = prs[i];
            @(negedge clk);
            chk($sformatf("tag_c%0d", i),
                {bus_a.zero_pdi, bus_a.pdo_valid, bus_a.pdo_byte_en,
                 bus_a.pdi_ready, bus_a.se, bus_a.skinny_start},
                {1'b1, 1'b1, 4'b1111, 1'b0, prs[i], 1'b0});
            @(posedge clk);
            #1;
        end
        pdo_ready = 1'b0;
        @(negedge clk);
        chk("tag_done", {bus_a.busy, bus_a.blk_done, bus_a.skinny_start},
            {1'b1, 1'b1, 1'b0});
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("tag_idle", bus_a.busy, 0);
        chk("tag_state", st, st_init);

        // Zero and oversize lengths act as 16 bytes
        bsel[0] = 5'd0;
        bsel[1] = 5'd20;
        for (int b = 0; b < 2; b++) begin
            do_reset();
            start_blk(2'b01, bsel[b], 1'b1);
            pdi_valid = 1'b1;
            pdo_ready = 1'b1;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                chk($sformatf("len%0d_beat%0d", bsel[b], k),
                    {bus_a.pdo_valid, bus_a.pdo_byte_en, bus_a.decrypt,
                     bus_a.se},
                    {1'b1, 4'b1111, 4'b1111, 1'b1});
                @(posedge clk);
                #1;
            end
        end

        // SKINNY never answers: TIMEOUT=8 instance must flag err
        do_reset();
        start_blk(2'b00, 5'd16, 1'b0);
        pdi_valid = 1'b1;
        pdo_ready = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            chk($sformatf("to_c%0d", c),
                {bus_t.busy, bus_t.err, bus_t.skinny_start,
                 bus_t.enc, bus_t.blk_done},
                {c <= 13, c >= 14, c == 5, 1'b0, 1'b0});
            @(posedge clk);
            #1;
        end
        start_blk(2'b00, 5'd16, 1'b0);
        @(negedge clk);
        chk("to_restart", {bus_t.busy, bus_t.se, bus_t.err},
            {1'b1, 1'b1, 1'b1});

        // Reset mid-ABSORB after two beats, then a clean block
        @(posedge clk);
        #1;
        do_reset();
        start_blk(2'b00, 5'd16, 1'b0);
        pdi_valid = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        #2 rst = 1'b0;
        #1;
        chk("rst_async_a", oa, 0);
        chk("rst_async_t", ot, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        start_blk(2'b00, 5'd16, 1'b0);
        pdi_valid = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            blk_start = (c == 2);
            blk_type = 2'b10;
            skinny_done = (c == 8);
            @(negedge clk);
            chk($sformatf("rr_c%0d", c),
                {bus_a.busy, bus_a.se, bus_a.skinny_start, bus_a.enc,
                 bus_a.blk_done, bus_a.zero_pdi},
                {c <= 10, c <= 4, c == 5, c == 9, c == 10, 1'b0});
            @(posedge clk);
            #1;
        end
        blk_start = 1'b0;
        skinny_done = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
